// File: rtl/elevator_ctrl_n_if.sv
// Call/sensor inputs and motor/door/display outputs of the elevator controller.
interface elevator_ctrl_n_if #(
  parameter int N_FLOORS = 4
);
  localparam int FLOOR_W = ($clog2(N_FLOORS) < 1) ? 1 : $clog2(N_FLOORS);

  logic [N_FLOORS-1:0] call_req;
  logic                estop;
  logic [FLOOR_W-1:0]  floor;
  logic                moving;
  logic                dir_up;
  logic                door_open;
  logic [N_FLOORS-1:0] pending;
  logic [2:0]          state;

  modport master (
    output call_req, estop,
    input  floor, moving, dir_up, door_open, pending, state
  );

  modport slave (
    input  call_req, estop,
    output floor, moving, dir_up, door_open, pending, state
  );
endinterface

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches calls, serves them with a SCAN
// policy, models per-floor travel time and door dwell, honours emergency stop.
module elevator_ctrl_n #(
  parameter int N_FLOORS      = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  elevator_ctrl_n_if.slave  bus
);
  localparam int FLOOR_W = ($clog2(N_FLOORS) < 1) ? 1 : $clog2(N_FLOORS);
  localparam int TRAV_W  = ($clog2(TRAVEL_CYCLES) < 1) ? 1 : $clog2(TRAVEL_CYCLES);
  localparam int DOOR_W  = ($clog2(DOOR_CYCLES) < 1) ? 1 : $clog2(DOOR_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR_OPEN = 3'd3,
    ESTOP     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [TRAV_W-1:0]   trav_q, trav_d;
  logic [DOOR_W-1:0]   door_cnt_q, door_cnt_d;
  logic                moving_q, door_q;

  logic                do_decide;
  logic [FLOOR_W-1:0]  dec_floor;
  logic [N_FLOORS-1:0] set_mask, clear_mask, here_mask, dec_mask;
  logic                ahead, behind;

  // One-hot mask selecting a given floor (safe for non-power-of-two floor counts)
  function automatic logic [N_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    logic [N_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < N_FLOORS; i++) m[i] = (i == int'(f));
    return m;
  endfunction

  // Any request strictly above (up=1) or strictly below (up=0) floor f
  function automatic logic any_beyond(input logic [N_FLOORS-1:0] p,
                                      input logic [FLOOR_W-1:0] f,
                                      input logic up);
    logic a;
    a = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) a = 1'b1;
    end
    return a;
  endfunction

  // Next-state, counters and request bookkeeping; Decide() runs on dec_floor when requested
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    trav_d     = trav_q;
    door_cnt_d = door_cnt_q;
    do_decide  = 1'b0;
    dec_floor  = floor_q;
    clear_mask = '0;
    here_mask  = floor_mask(floor_q);
    set_mask   = bus.call_req;
    if (state_q == DOOR_OPEN) set_mask = bus.call_req & ~here_mask;

    case (state_q)
      IDLE: do_decide = 1'b1;
      MOVE_UP, MOVE_DOWN: begin
        if (trav_q == TRAV_W'(TRAVEL_CYCLES - 1)) begin
          floor_d   = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          trav_d    = '0;
          do_decide = 1'b1;
          dec_floor = floor_d;
        end else begin
          trav_d = trav_q + TRAV_W'(1);
        end
      end
      DOOR_OPEN: begin
        if (|(bus.call_req & here_mask)) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_W'(DOOR_CYCLES - 1)) begin
          do_decide = 1'b1;
        end else begin
          door_cnt_d = door_cnt_q + DOOR_W'(1);
        end
      end
      ESTOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    dec_mask = floor_mask(dec_floor);
    ahead    = any_beyond(pending_q, dec_floor, dir_q);
    behind   = any_beyond(pending_q, dec_floor, ~dir_q);

    if (do_decide) begin
      trav_d = '0;
      if (|(pending_q & dec_mask)) begin
        state_d    = DOOR_OPEN;
        clear_mask = dec_mask;
        door_cnt_d = '0;
      end else if (ahead) begin
        state_d = dir_q ? MOVE_UP : MOVE_DOWN;
      end else if (behind) begin
        dir_d   = ~dir_q;
        state_d = dir_q ? MOVE_DOWN : MOVE_UP;
      end else begin
        state_d = IDLE;
      end
    end

    if (bus.estop) begin
      state_d    = ESTOP;
      floor_d    = floor_q;
      dir_d      = dir_q;
      trav_d     = '0;
      door_cnt_d = '0;
      clear_mask = '0;
    end

    pending_d = (pending_q | set_mask) & ~clear_mask;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      floor_q    <= '0;
      dir_q      <= 1'b1;
      pending_q  <= '0;
      trav_q     <= '0;
      door_cnt_q <= '0;
      moving_q   <= 1'b0;
      door_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_q      <= dir_d;
      pending_q  <= pending_d;
      trav_q     <= trav_d;
      door_cnt_q <= door_cnt_d;
      moving_q   <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
      door_q     <= (state_d == DOOR_OPEN);
    end
  end

  assign bus.floor     = floor_q;
  assign bus.moving    = moving_q;
  assign bus.dir_up    = dir_q;
  assign bus.door_open = door_q;
  assign bus.pending   = pending_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed scoreboard bench for elevator_ctrl_n (4 floors, travel 2, dwell 3).
module tb_elevator_ctrl_n;
  localparam int N = 4;

  typedef enum int {F_STATE, F_FLOOR, F_MOVING, F_DIR, F_DOOR, F_PEND} field_e;

  typedef struct {
    string  tag;
    int     due;
    field_e fld;
    int     val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_n = 0;
  int   base = 0;
  int   checks = 0;
  int   passes = 0;
  int   fails = 0;
  exp_t sb[$];

  elevator_ctrl_n_if #(.N_FLOORS(N)) bus ();

  elevator_ctrl_n #(.N_FLOORS(N), .TRAVEL_CYCLES(2), .DOOR_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] observed(input field_e f);
    case (f)
      F_STATE:  return 32'(bus.state);
      F_FLOOR:  return 32'(bus.floor);
      F_MOVING: return 32'(bus.moving);
      F_DIR:    return 32'(bus.dir_up);
      F_DOOR:   return 32'(bus.door_open);
      default:  return 32'(bus.pending);
    endcase
  endfunction

  task automatic push_exp(input string tag, input int rel, input field_e f, input int v);
    exp_t e;
    e.tag = tag; e.due = base + rel; e.fld = f; e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_reset_exp(input string tag, input int rel);
    push_exp({tag, "_state"},  rel, F_STATE,  0);
    push_exp({tag, "_floor"},  rel, F_FLOOR,  0);
    push_exp({tag, "_dir"},    rel, F_DIR,    1);
    push_exp({tag, "_door"},   rel, F_DOOR,   0);
    push_exp({tag, "_moving"}, rel, F_MOVING, 0);
    push_exp({tag, "_pend"},   rel, F_PEND,   0);
  endtask

  task automatic checkOutput();
    int i;
    logic [31:0] obs;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == edge_n) begin
        obs = observed(sb[i].fld);
        checks++;
        assert (obs === 32'(sb[i].val)) passes++;
        else begin
          fails++;
          $error("[TB] FAIL %s @edge %0d: got %0d expected %0d", sb[i].tag, edge_n, obs, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] call, input logic es);
    bus.call_req = call;
    bus.estop    = es;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      edge_n++;
      #1;
      checkOutput();
    end
  endtask

  task automatic do_reset(input string tag);
    base  = edge_n;
    rst_n = 1'b0;
    applyStimulus('0, 1'b0);
    push_reset_exp(tag, 1);
    tick(2);
    rst_n = 1'b1;
  endtask

  // Directed scenario sequence
  initial begin
    applyStimulus('0, 1'b0);
    do_reset("rst");

    // Call to floor 2 from ground: latch, move, arrive, dwell, idle
    base = edge_n;
    push_exp("t1_pend_latch", 1, F_PEND, 4);
    push_exp("t1_idle_e1",    1, F_STATE, 0);
    push_exp("t1_move_up",    2, F_STATE, 1);
    push_exp("t1_moving",     2, F_MOVING, 1);
    push_exp("t1_floor0_e3",  3, F_FLOOR, 0);
    push_exp("t1_floor1",     4, F_FLOOR, 1);
    push_exp("t1_still_up",   4, F_STATE, 1);
    push_exp("t1_floor2",     6, F_FLOOR, 2);
    push_exp("t1_door",       6, F_DOOR, 1);
    push_exp("t1_pend_clr",   6, F_PEND, 0);
    push_exp("t1_state_door", 6, F_STATE, 3);
    push_exp("t1_door_e8",    8, F_DOOR, 1);
    push_exp("t1_door_shut",  9, F_DOOR, 0);
    push_exp("t1_idle",       9, F_STATE, 0);
    applyStimulus(4'b0100, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(9);

    // Call to the floor the car already sits on: door opens, no motion
    do_reset("rst2");
    base = edge_n;
    push_exp("t2_door_state", 2, F_STATE, 3);
    push_exp("t2_pend",       2, F_PEND, 0);
    push_exp("t2_no_move",    2, F_MOVING, 0);
    push_exp("t2_door_e4",    4, F_DOOR, 1);
    push_exp("t2_idle",       5, F_STATE, 0);
    push_exp("t2_floor",      5, F_FLOOR, 0);
    applyStimulus(4'b0001, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(4);

    // Top and bottom requests: stop at top, reverse, travel to ground
    base = edge_n;
    push_exp("t3_pend_both",  5,  F_PEND, 9);
    push_exp("t3_floor3",     8,  F_FLOOR, 3);
    push_exp("t3_door_top",   8,  F_STATE, 3);
    push_exp("t3_pend_low",   8,  F_PEND, 1);
    push_exp("t3_floor_cap",  10, F_FLOOR, 3);
    push_exp("t3_move_down",  11, F_STATE, 2);
    push_exp("t3_dir_down",   11, F_DIR, 0);
    push_exp("t3_floor_cap2", 12, F_FLOOR, 3);
    push_exp("t3_floor2",     13, F_FLOOR, 2);
    push_exp("t3_floor0",     17, F_FLOOR, 0);
    push_exp("t3_door_gnd",   17, F_DOOR, 1);
    push_exp("t3_pend_empty", 17, F_PEND, 0);
    push_exp("t3_idle",       20, F_STATE, 0);
    applyStimulus(4'b1000, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(3);
    applyStimulus(4'b0001, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(15);

    // Same-floor call on the last dwell cycle extends the dwell
    base = edge_n;
    push_exp("t4_dir_up",     2,  F_DIR, 1);
    push_exp("t4_move_up",    2,  F_STATE, 1);
    push_exp("t4_door",       6,  F_DOOR, 1);
    push_exp("t4_extended",   9,  F_DOOR, 1);
    push_exp("t4_no_latch",   9,  F_PEND, 0);
    push_exp("t4_door_e11",   11, F_DOOR, 1);
    push_exp("t4_closed",     12, F_DOOR, 0);
    push_exp("t4_idle",       12, F_STATE, 0);
    applyStimulus(4'b0100, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(7);
    applyStimulus(4'b0100, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(3);

    // Emergency stop mid-travel between floors 1 and 2
    do_reset("rst5");
    base = edge_n;
    push_exp("t5_estop",        6,  F_STATE, 4);
    push_exp("t5_estop_floor",  6,  F_FLOOR, 1);
    push_exp("t5_estop_still",  6,  F_MOVING, 0);
    push_exp("t5_estop_hold",   7,  F_STATE, 4);
    push_exp("t5_estop_latch",  7,  F_PEND, 5);
    push_exp("t5_release_idle", 8,  F_STATE, 0);
    push_exp("t5_pend_kept",    8,  F_PEND, 5);
    push_exp("t5_resume_up",    9,  F_STATE, 1);
    push_exp("t5_full_travel",  10, F_FLOOR, 1);
    push_exp("t5_floor2",       11, F_FLOOR, 2);
    push_exp("t5_door2",        11, F_DOOR, 1);
    applyStimulus(4'b0100, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(4);
    applyStimulus('0, 1'b1);
    tick();
    applyStimulus(4'b0001, 1'b1);
    tick();
    applyStimulus('0, 1'b0);
    tick(4);

    // Reset asserted during a dwell with outstanding requests
    do_reset("rst6");
    base = edge_n;
    push_exp("t6_pend_1010", 7, F_PEND, 10);
    push_exp("t6_door",      7, F_DOOR, 1);
    push_reset_exp("t6_rst", 8);
    applyStimulus(4'b0100, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(5);
    applyStimulus(4'b1010, 1'b0);
    tick();
    rst_n = 1'b0;
    applyStimulus('0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick(2);

    checks++;
    assert (sb.size() == 0) passes++;
    else begin
      fails++;
      $error("[TB] FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
